// File: rtl/aes_pkg.sv
// Shared AES constants and the round-sequencer state encoding.
package aes_pkg;

    localparam int AES_BLK_W = 128;

    localparam int NR_AES128 = 10;
    localparam int NR_AES192 = 12;
    localparam int NR_AES256 = 14;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } aes_sched_state_t;

endpackage

// File: rtl/aes_round_sched_if.sv
// Host-side block port of the AES round sequencer: input block, result block and busy.
interface aes_round_sched_if;
    import aes_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [AES_BLK_W-1:0] in_data;
    logic                 in_decrypt;
    logic                 out_valid;
    logic                 out_ready;
    logic [AES_BLK_W-1:0] out_data;
    logic                 busy;

    // The host (accelerator front end) drives blocks in and consumes results.
    modport master (
        output in_valid, in_data, in_decrypt, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, in_decrypt, out_ready,
        output in_ready, out_valid, out_data, busy
    );

endinterface

// File: rtl/aes_round_sched.sv
// AES round sequencer: whitens the input block with the first round key, then drives
// NR rounds through the shared round datapath and returns the result over valid/ready.
module aes_round_sched
    import aes_pkg::*;
#(
    parameter int NR       = NR_AES128,
    parameter int RK_IDX_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    aes_round_sched_if.slave     host,
    output logic [RK_IDX_W-1:0]  rk_idx,
    input  logic [AES_BLK_W-1:0] rk_data,
    output logic                 rnd_in_valid,
    output logic [AES_BLK_W-1:0] rnd_state,
    output logic [AES_BLK_W-1:0] rnd_key,
    output logic                 rnd_decrypt,
    output logic                 rnd_final,
    input  logic [AES_BLK_W-1:0] rnd_out,
    input  logic                 rnd_out_valid
);

    localparam logic [RK_IDX_W-1:0] NR_IDX = RK_IDX_W'(NR);
    localparam logic [RK_IDX_W-1:0] RCNT_1 = RK_IDX_W'(1);

    if (NR != NR_AES128 && NR != NR_AES192 && NR != NR_AES256) begin : g_bad_nr
        $error("aes_round_sched: NR must be 10, 12 or 14");
    end

    if ((2 ** RK_IDX_W) <= NR) begin : g_bad_idx_w
        $error("aes_round_sched: RK_IDX_W too narrow to index round key NR");
    end

    aes_sched_state_t     fsm_q, fsm_d;
    logic [AES_BLK_W-1:0] state_q, state_d;
    logic                 dir_q, dir_d;
    logic [RK_IDX_W-1:0]  rcnt_q, rcnt_d;
    logic                 last_round;

    assign last_round = (rcnt_q == NR_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            dir_q   <= 1'b0;
            rcnt_q  <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            dir_q   <= dir_d;
            rcnt_q  <= rcnt_d;
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        dir_d   = dir_q;
        rcnt_d  = rcnt_q;
        case (fsm_q)
            IDLE: begin
                // rk_data already carries the whitening key selected from in_decrypt.
                if (host.in_valid) begin
                    state_d = host.in_data ^ rk_data;
                    dir_d   = host.in_decrypt;
                    rcnt_d  = RCNT_1;
                    fsm_d   = ISSUE;
                end
            end
            ISSUE: begin
                fsm_d = WAIT;
            end
            WAIT: begin
                if (rnd_out_valid) begin
                    state_d = rnd_out;
                    if (last_round) begin
                        fsm_d = DONE;
                    end else begin
                        rcnt_d = rcnt_q + RCNT_1;
                        fsm_d  = ISSUE;
                    end
                end
            end
            DONE: begin
                if (host.out_ready) begin
                    fsm_d = IDLE;
                end
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    // Decryption walks the key schedule backwards from NR down to 0.
    always_comb begin
        if (fsm_q == IDLE) begin
            rk_idx = host.in_decrypt ? NR_IDX : '0;
        end else begin
            rk_idx = dir_q ? (NR_IDX - rcnt_q) : rcnt_q;
        end
    end

    assign rnd_in_valid = (fsm_q == ISSUE);
    assign rnd_state    = state_q;
    assign rnd_key      = rk_data;
    assign rnd_decrypt  = dir_q;
    assign rnd_final    = last_round;

    assign host.in_ready  = (fsm_q == IDLE);
    assign host.out_valid = (fsm_q == DONE);
    assign host.out_data  = state_q;
    assign host.busy      = (fsm_q != IDLE);

endmodule

// File: tb/tb_aes_round_sched.sv
// Directed bench for aes_round_sched with a behavioural AES round unit and key store.
module tb_aes_round_sched;
    import aes_pkg::*;

    localparam int NR  = NR_AES128;
    localparam int RKW = 4;
    localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] JUNK = 128'hdeadbeef_0badf00d_cafebabe_55aa55aa;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    aes_round_sched_if host ();

    logic [RKW-1:0] rk_idx;
    logic [127:0]   rk_data;
    logic           rnd_in_valid;
    logic [127:0]   rnd_state;
    logic [127:0]   rnd_key;
    logic           rnd_decrypt;
    logic           rnd_final;
    logic [127:0]   rnd_out;
    logic           rnd_out_valid;

    aes_round_sched #(.NR(NR), .RK_IDX_W(RKW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .host         (host),
        .rk_idx       (rk_idx),
        .rk_data      (rk_data),
        .rnd_in_valid (rnd_in_valid),
        .rnd_state    (rnd_state),
        .rnd_key      (rnd_key),
        .rnd_decrypt  (rnd_decrypt),
        .rnd_final    (rnd_final),
        .rnd_out      (rnd_out),
        .rnd_out_valid(rnd_out_valid)
    );

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0]   sbox_t  [256];
    logic [7:0]   isbox_t [256];
    logic [127:0] rks     [16];

    // ---------------- AES arithmetic for the round-unit model ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] gb(input logic [127:0] s, input int i);
        return s[127-8*i -: 8];
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s, input bit inv);
        logic [127:0] o;
        for (int i = 0; i < 16; i++)
            o[127-8*i -: 8] = inv ? isbox_t[gb(s, i)] : sbox_t[gb(s, i)];
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s, input bit inv);
        logic [127:0] o;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!inv) o[127-8*(r+4*c) -: 8] = gb(s, r + 4*((c+r)%4));
                else      o[127-8*(r+4*((c+r)%4)) -: 8] = gb(s, r + 4*c);
        return o;
    endfunction

    function automatic logic [127:0] mix_cols(input logic [127:0] s, input bit inv);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = gb(s, 4*c); a1 = gb(s, 4*c+1); a2 = gb(s, 4*c+2); a3 = gb(s, 4*c+3);
            if (!inv) begin
                o[127-8*(4*c)   -: 8] = gmul(a0,8'h02) ^ gmul(a1,8'h03) ^ a2 ^ a3;
                o[127-8*(4*c+1) -: 8] = a0 ^ gmul(a1,8'h02) ^ gmul(a2,8'h03) ^ a3;
                o[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ gmul(a2,8'h02) ^ gmul(a3,8'h03);
                o[127-8*(4*c+3) -: 8] = gmul(a0,8'h03) ^ a1 ^ a2 ^ gmul(a3,8'h02);
            end else begin
                o[127-8*(4*c)   -: 8] = gmul(a0,8'h0e) ^ gmul(a1,8'h0b) ^ gmul(a2,8'h0d) ^ gmul(a3,8'h09);
                o[127-8*(4*c+1) -: 8] = gmul(a0,8'h09) ^ gmul(a1,8'h0e) ^ gmul(a2,8'h0b) ^ gmul(a3,8'h0d);
                o[127-8*(4*c+2) -: 8] = gmul(a0,8'h0d) ^ gmul(a1,8'h09) ^ gmul(a2,8'h0e) ^ gmul(a3,8'h0b);
                o[127-8*(4*c+3) -: 8] = gmul(a0,8'h0b) ^ gmul(a1,8'h0d) ^ gmul(a2,8'h09) ^ gmul(a3,8'h0e);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] k, input bit fin);
        logic [127:0] t;
        t = shift_rows(sub_bytes(s, 1'b0), 1'b0);
        if (!fin) t = mix_cols(t, 1'b0);
        return t ^ k;
    endfunction

    function automatic logic [127:0] dec_round(input logic [127:0] s, input logic [127:0] k, input bit fin);
        logic [127:0] t;
        t = sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ k;
        if (!fin) t = mix_cols(t, 1'b1);
        return t;
    endfunction

    task automatic build_tables();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_t[x] = inv ^ rotl8(inv,1) ^ rotl8(inv,2) ^ rotl8(inv,3) ^ rotl8(inv,4) ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) isbox_t[sbox_t[x]] = 8'(x);
    endtask

    task automatic key_expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 16; r++) begin
            if (r <= 10) rks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            else         rks[r] = '0;
        end
    endtask

    // ---------------- key store and round unit with latency lat ----------------
    assign rk_data = rks[rk_idx];

    int           lat      = 1;
    bit           spur_en  = 1'b0;
    int           pend_cnt = 0;
    logic [127:0] pend_res = '0;
    logic         spur;

    assign spur          = spur_en && (rnd_in_valid || host.out_valid || host.in_ready);
    assign rnd_out_valid = (pend_cnt == 1) || spur;
    assign rnd_out       = spur ? JUNK : pend_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_cnt <= 0;
        end else if (rnd_in_valid) begin
            pend_cnt <= lat;
            pend_res <= rnd_decrypt ? dec_round(rnd_state, rnd_key, rnd_final)
                                    : enc_round(rnd_state, rnd_key, rnd_final);
        end else if (pend_cnt != 0) begin
            pend_cnt <= pend_cnt - 1;
        end
    end

    logic [RKW-1:0] idx_log [$];
    logic           fin_log [$];

    always @(negedge clk) begin
        if (rst_n && rnd_in_valid) begin
            idx_log.push_back(rk_idx);
            fin_log.push_back(rnd_final);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_block(input logic [127:0] d, input logic dec,
                             output logic [127:0] res, output int cyc);
        host.in_data    = d;
        host.in_decrypt = dec;
        host.in_valid   = 1'b1;
        for (int w = 0; w < 50 && host.in_ready !== 1'b1; w++) tick();
        tick();
        host.in_valid = 1'b0;
        cyc = 1;
        while (host.out_valid !== 1'b1 && cyc < 400) begin
            tick();
            cyc++;
        end
        if (host.out_valid !== 1'b1) cyc = -1;
        res = host.out_data;
    endtask

    task automatic finish_block();
        host.out_ready = 1'b1;
        tick();
        host.out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        host.in_valid = 1'b0; host.in_decrypt = 1'b0; host.in_data = '0; host.out_ready = 1'b0;
        #2;
        n_total++; if (host.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", host.in_ready); else n_pass++;
        n_total++; if (host.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", host.out_valid); else n_pass++;
        n_total++; if (rnd_in_valid !== 1'b0) $display("FAIL reset_rnd_in_valid: got %b want 0", rnd_in_valid); else n_pass++;
        n_total++; if (host.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", host.busy); else n_pass++;
        n_total++; if (host.out_data !== 128'h0) $display("FAIL reset_out_data: got %h want 0", host.out_data); else n_pass++;
        n_total++; if (rk_idx !== 4'd0) $display("FAIL reset_rk_idx: got %0d want 0", rk_idx); else n_pass++;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_encrypt();
        logic [127:0] res;
        int cyc;
        logic [9:0] fins;
        idx_log.delete(); fin_log.delete();
        host.in_decrypt = 1'b0;
        #1;
        n_total++; if (rk_idx !== 4'd0) $display("FAIL enc_whiten_idx: got %0d want 0", rk_idx); else n_pass++;
        run_block(PT, 1'b0, res, cyc);
        n_total++; if (res !== CT) $display("FAIL enc_result: got %h want %h", res, CT); else n_pass++;
        n_total++; if (cyc != 21) $display("FAIL enc_latency: got %0d want 21", cyc); else n_pass++;
        n_total++; if (host.in_ready !== 1'b0 || host.busy !== 1'b1) $display("FAIL enc_done_flags: in_ready %b busy %b want 0 1", host.in_ready, host.busy); else n_pass++;
        n_total++; if (idx_log.size() != 10) $display("FAIL enc_issue_count: got %0d want 10", idx_log.size()); else n_pass++;
        fins = '0;
        for (int i = 0; i < idx_log.size() && i < 10; i++) begin
            fins[i] = fin_log[i];
            n_total++; if (idx_log[i] !== 4'(i + 1)) $display("FAIL enc_rk_idx[%0d]: got %0d want %0d", i, idx_log[i], i + 1); else n_pass++;
        end
        n_total++; if (fins !== 10'b10_0000_0000) $display("FAIL enc_final_flags: got %b want 1000000000", fins); else n_pass++;
        finish_block();
        n_total++; if (host.in_ready !== 1'b1 || host.out_valid !== 1'b0 || host.busy !== 1'b0) $display("FAIL enc_after_handshake: in_ready %b out_valid %b busy %b want 1 0 0", host.in_ready, host.out_valid, host.busy); else n_pass++;
    endtask

    task automatic test_decrypt();
        logic [127:0] res;
        int cyc;
        logic [9:0] fins;
        idx_log.delete(); fin_log.delete();
        host.in_decrypt = 1'b1;
        #1;
        n_total++; if (rk_idx !== 4'd10) $display("FAIL dec_whiten_idx: got %0d want 10", rk_idx); else n_pass++;
        run_block(CT, 1'b1, res, cyc);
        n_total++; if (res !== PT) $display("FAIL dec_result: got %h want %h", res, PT); else n_pass++;
        n_total++; if (cyc != 21) $display("FAIL dec_latency: got %0d want 21", cyc); else n_pass++;
        n_total++; if (idx_log.size() != 10) $display("FAIL dec_issue_count: got %0d want 10", idx_log.size()); else n_pass++;
        fins = '0;
        for (int i = 0; i < idx_log.size() && i < 10; i++) begin
            fins[i] = fin_log[i];
            n_total++; if (idx_log[i] !== 4'(9 - i)) $display("FAIL dec_rk_idx[%0d]: got %0d want %0d", i, idx_log[i], 9 - i); else n_pass++;
        end
        n_total++; if (fins !== 10'b10_0000_0000) $display("FAIL dec_final_flags: got %b want 1000000000", fins); else n_pass++;
        finish_block();
    endtask

    task automatic test_out_stall();
        logic [127:0] res;
        int cyc;
        run_block(PT, 1'b0, res, cyc);
        n_total++; if (res !== CT) $display("FAIL stall_result: got %h want %h", res, CT); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_total++;
            if (host.out_valid !== 1'b1 || host.out_data !== CT || host.in_ready !== 1'b0)
                $display("FAIL stall_hold[%0d]: out_valid %b in_ready %b data %h want 1 0 %h", i, host.out_valid, host.in_ready, host.out_data, CT);
            else n_pass++;
        end
        finish_block();
        n_total++; if (host.in_ready !== 1'b1) $display("FAIL stall_ready_after_hs: got %b want 1", host.in_ready); else n_pass++;
        run_block(CT, 1'b1, res, cyc);
        n_total++; if (res !== PT || cyc != 21) $display("FAIL stall_next_block: got %h after %0d want %h after 21", res, cyc, PT); else n_pass++;
        finish_block();
    endtask

    task automatic test_reset_mid();
        logic [127:0] res;
        int cyc, issues, stale;
        host.in_data = PT; host.in_decrypt = 1'b0; host.in_valid = 1'b1;
        tick();
        host.in_valid = 1'b0;
        issues = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (rnd_in_valid === 1'b1) issues++;
            else if (issues == 4) break;
        end
        n_total++; if (issues != 4 || host.busy !== 1'b1) $display("FAIL rstmid_reach_wait4: issues %0d busy %b want 4 1", issues, host.busy); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (host.busy !== 1'b0 || host.in_ready !== 1'b1 || host.out_valid !== 1'b0 || rnd_in_valid !== 1'b0 || host.out_data !== 128'h0)
            $display("FAIL rstmid_flags: busy %b in_ready %b out_valid %b rnd_in_valid %b data %h want 0 1 0 0 0", host.busy, host.in_ready, host.out_valid, rnd_in_valid, host.out_data);
        else n_pass++;
        tick(); tick();
        rst_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (host.out_valid !== 1'b0) stale++;
        end
        n_total++; if (stale != 0) $display("FAIL rstmid_stale_out: got %0d valid cycles want 0", stale); else n_pass++;
        run_block(PT, 1'b0, res, cyc);
        n_total++; if (res !== CT || cyc != 21) $display("FAIL rstmid_result: got %h after %0d want %h after 21", res, cyc, CT); else n_pass++;
        finish_block();
    endtask

    task automatic test_spurious();
        logic [127:0] res;
        int cyc;
        lat = 3;
        spur_en = 1'b1;
        tick();
        run_block(PT, 1'b0, res, cyc);
        n_total++; if (res !== CT) $display("FAIL spur_result: got %h want %h", res, CT); else n_pass++;
        n_total++; if (cyc != 41) $display("FAIL spur_latency: got %0d want 41", cyc); else n_pass++;
        tick(); tick();
        n_total++; if (host.out_valid !== 1'b1 || host.out_data !== CT) $display("FAIL spur_done_hold: valid %b data %h want 1 %h", host.out_valid, host.out_data, CT); else n_pass++;
        finish_block();
        tick(); tick();
        n_total++; if (host.in_ready !== 1'b1 || host.busy !== 1'b0) $display("FAIL spur_idle_hold: in_ready %b busy %b want 1 0", host.in_ready, host.busy); else n_pass++;
        spur_en = 1'b0;
        lat = 1;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [127:0] outs_d [2];
        int t_out [2];
        int outs, ready_between;
        bit drop;
        outs_d[0] = '0; outs_d[1] = '0; t_out[0] = 0; t_out[1] = 0;
        outs = 0; ready_between = 0; drop = 1'b0;
        host.out_ready = 1'b1;
        host.in_data = PT; host.in_decrypt = 1'b0; host.in_valid = 1'b1;
        tick();
        host.in_data = CT; host.in_decrypt = 1'b1;
        for (int c = 1; c < 200 && outs < 2; c++) begin
            tick();
            if (drop) begin
                host.in_valid = 1'b0;
                drop = 1'b0;
            end
            if (host.out_valid === 1'b1) begin
                outs_d[outs] = host.out_data;
                t_out[outs] = c;
                outs++;
            end
            if (host.in_ready === 1'b1) begin
                if (outs == 1) ready_between++;
                if (host.in_valid) drop = 1'b1;
            end
        end
        tick();
        host.out_ready = 1'b0;
        host.in_valid = 1'b0;
        n_total++; if (outs != 2) $display("FAIL b2b_out_count: got %0d want 2", outs); else n_pass++;
        n_total++; if (outs_d[0] !== CT) $display("FAIL b2b_first: got %h want %h", outs_d[0], CT); else n_pass++;
        n_total++; if (outs_d[1] !== PT) $display("FAIL b2b_second: got %h want %h", outs_d[1], PT); else n_pass++;
        n_total++; if (t_out[1] - t_out[0] != 22) $display("FAIL b2b_spacing: got %0d want 22", t_out[1] - t_out[0]); else n_pass++;
        n_total++; if (ready_between != 1) $display("FAIL b2b_in_ready_pulse: got %0d want 1", ready_between); else n_pass++;
        n_total++; if (host.busy !== 1'b0 || host.out_valid !== 1'b0) $display("FAIL b2b_idle_after: busy %b out_valid %b want 0 0", host.busy, host.out_valid); else n_pass++;
    endtask

    initial begin
        build_tables();
        key_expand(KEY);
        test_reset();
        test_encrypt();
        test_decrypt();
        test_out_stall();
        test_reset_mid();
        test_spurious();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end

endmodule
